// File: rtl/jtframe_vidreplay_pkg.sv
// Shared constants for the video replay block: default raster timing,
// the expected alpha value and where the displayed nibbles sit in a pixel word.
package jtframe_vidreplay_pkg;

  localparam int DEF_HTOTAL   = 384;
  localparam int DEF_HACTIVE  = 256;
  localparam int DEF_HS_START = 288;
  localparam int DEF_HS_LEN   = 32;
  localparam int DEF_VTOTAL   = 264;
  localparam int DEF_VACTIVE  = 224;
  localparam int DEF_VS_START = 240;
  localparam int DEF_VS_LEN   = 4;
  localparam int DEF_FIFO_AW  = 4;

  localparam int WORD_W = 32;

  localparam logic [7:0] ALPHA_OK = 8'hff;

  localparam int ALPHA_HI = 31;
  localparam int ALPHA_LO = 24;
  localparam int R_HI     = 23;
  localparam int R_LO     = 20;
  localparam int G_HI     = 15;
  localparam int G_LO     = 12;
  localparam int B_HI     = 7;
  localparam int B_LO     = 4;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  // Keep only the upper nibble of each 8-bit colour channel.
  function automatic rgb_t word_to_rgb(input logic [WORD_W-1:0] w);
    rgb_t p;
    p.r = w[R_HI:R_LO];
    p.g = w[G_HI:G_LO];
    p.b = w[B_HI:B_LO];
    return p;
  endfunction

  function automatic logic alpha_bad(input logic [WORD_W-1:0] w);
    return w[ALPHA_HI:ALPHA_LO] != ALPHA_OK;
  endfunction

endpackage

// File: rtl/jtframe_vidreplay_fifo.sv
// Pixel-word FIFO between the upstream reader and the raster generator.
// The read word lands in a register on the pop edge; there is no bypass path.
module jtframe_vidreplay_fifo
  import jtframe_vidreplay_pkg::*;
#(
  parameter int AW = DEF_FIFO_AW,
  parameter int DW = WORD_W
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr_reg;
  logic [AW:0]   rd_ptr_reg;
  logic [DW-1:0] dout_reg;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra wrap bit, so the difference is the exact fill level.
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign full    = level[AW];
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = dout_reg;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      dout_reg   <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop) begin
        dout_reg   <= mem[rd_ptr_reg[AW-1:0]];
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/jtframe_vidreplay.sv
// Turns a stream of ARGB pixel words back into raster video with sync,
// blanking and 4-bit RGB, starting once the FIFO is half full.
module jtframe_vidreplay
  import jtframe_vidreplay_pkg::*;
#(
  parameter int HTOTAL   = DEF_HTOTAL,
  parameter int HACTIVE  = DEF_HACTIVE,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_LEN   = DEF_HS_LEN,
  parameter int VTOTAL   = DEF_VTOTAL,
  parameter int VACTIVE  = DEF_VACTIVE,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_LEN   = DEF_VS_LEN,
  parameter int FIFO_AW  = DEF_FIFO_AW
)(
  input  logic        pxl_clk,
  input  logic        rst_base,
  input  logic        pxl_cen,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        HS,
  output logic        VS,
  output logic        pxl_hb,
  output logic        pxl_vb,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic [31:0] frame_cnt,
  output logic        underrun,
  output logic        fmt_err,
  output logic        running
);

  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  localparam logic [FIFO_AW:0] PRIME_LEVEL = (FIFO_AW+1)'(2 ** (FIFO_AW - 1));

  logic [HW-1:0]      h_reg;
  logic [VW-1:0]      v_reg;
  logic               running_reg;
  logic               hb_reg;
  logic               vb_reg;
  logic               hs_reg;
  logic               vs_reg;
  logic               show_reg;
  logic               vb_prev_reg;
  logic               underrun_reg;
  logic               fmt_hist_reg;
  logic [31:0]        frame_cnt_reg;

  logic [WORD_W-1:0]  fifo_dout;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_AW:0]   fifo_level;

  logic               step;
  logic               h_act;
  logic               v_act;
  logic               h_last;
  logic               v_last;
  logic               pop_due;
  logic               pop;
  logic               fmt_now;
  rgb_t               pix;

  jtframe_vidreplay_fifo #(
    .AW (FIFO_AW),
    .DW (WORD_W)
  ) u_fifo (
    .clk   (pxl_clk),
    .rst   (rst_base),
    .push  (in_valid),
    .din   (in_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    step    = running_reg && pxl_cen;
    h_act   = int'(h_reg) < HACTIVE;
    v_act   = int'(v_reg) < VACTIVE;
    h_last  = int'(h_reg) == HTOTAL - 1;
    v_last  = int'(v_reg) == VTOTAL - 1;
    pop_due = step && h_act && v_act;
    pop     = pop_due && !fifo_empty;
    pix     = word_to_rgb(fifo_dout);
    // The shown word sits in the FIFO output register, so its alpha is judged there.
    fmt_now = show_reg && alpha_bad(fifo_dout);
  end

  always_ff @(posedge pxl_clk or posedge rst_base) begin
    if (rst_base) begin
      h_reg         <= '0;
      v_reg         <= '0;
      running_reg   <= 1'b0;
      hb_reg        <= 1'b1;
      vb_reg        <= 1'b1;
      hs_reg        <= 1'b0;
      vs_reg        <= 1'b0;
      show_reg      <= 1'b0;
      vb_prev_reg   <= 1'b1;
      underrun_reg  <= 1'b0;
      fmt_hist_reg  <= 1'b0;
      frame_cnt_reg <= '0;
    end else begin
      if (fifo_level >= PRIME_LEVEL) running_reg <= 1'b1;
      vb_prev_reg <= vb_reg;
      if (vb_reg && !vb_prev_reg) frame_cnt_reg <= frame_cnt_reg + 32'd1;
      if (fmt_now) fmt_hist_reg <= 1'b1;
      if (step) begin
        h_reg <= h_last ? '0 : h_reg + HW'(1);
        if (h_last) v_reg <= v_last ? '0 : v_reg + VW'(1);
        hb_reg   <= !h_act;
        vb_reg   <= !v_act;
        hs_reg   <= (int'(h_reg) >= HS_START) && (int'(h_reg) < HS_START + HS_LEN);
        vs_reg   <= (int'(v_reg) >= VS_START) && (int'(v_reg) < VS_START + VS_LEN);
        show_reg <= pop;
        if (pop_due && fifo_empty) underrun_reg <= 1'b1;
      end
    end
  end

  assign in_ready  = !fifo_full;
  assign HS        = hs_reg;
  assign VS        = vs_reg;
  assign pxl_hb    = hb_reg;
  assign pxl_vb    = vb_reg;
  assign red       = show_reg ? pix.r : 4'h0;
  assign green     = show_reg ? pix.g : 4'h0;
  assign blue      = show_reg ? pix.b : 4'h0;
  assign frame_cnt = frame_cnt_reg;
  assign underrun  = underrun_reg;
  assign fmt_err   = fmt_hist_reg | fmt_now;
  assign running   = running_reg;

endmodule

// File: tb/tb_jtframe_vidreplay.sv
// Scoreboard bench for the video replay block on a tiny 8x5 raster.
// Accepted words are queued as expected pixels; a monitor checks every clock.
module tb_jtframe_vidreplay;

  localparam int HTOTAL   = 8;
  localparam int HACTIVE  = 4;
  localparam int HS_START = 5;
  localparam int HS_LEN   = 1;
  localparam int VTOTAL   = 5;
  localparam int VACTIVE  = 3;
  localparam int VS_START = 4;
  localparam int VS_LEN   = 1;
  localparam int FIFO_AW  = 3;
  localparam int DEPTH    = 8;
  localparam int PRIME    = 4;

  logic        pxl_clk  = 1'b0;
  logic        rst_base = 1'b1;
  logic        pxl_cen  = 1'b0;
  logic [31:0] in_data  = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, HS, VS, pxl_hb, pxl_vb, underrun, fmt_err, running;
  logic [3:0]  red, green, blue;
  logic [31:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cen_mode = 0;

  typedef struct {
    logic [11:0] rgb;
    bit          bad;
  } exp_t;

  exp_t        exp_q[$];
  bit          m_run;
  int          m_n;
  bit          e_hb, e_vb, e_hs, e_vs, e_und, e_fmt, fc_pend;
  logic [11:0] e_rgb;
  logic [31:0] e_fc;

  jtframe_vidreplay #(
    .HTOTAL(HTOTAL), .HACTIVE(HACTIVE), .HS_START(HS_START), .HS_LEN(HS_LEN),
    .VTOTAL(VTOTAL), .VACTIVE(VACTIVE), .VS_START(VS_START), .VS_LEN(VS_LEN),
    .FIFO_AW(FIFO_AW)
  ) dut (
    .pxl_clk(pxl_clk), .rst_base(rst_base), .pxl_cen(pxl_cen),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .HS(HS), .VS(VS), .pxl_hb(pxl_hb), .pxl_vb(pxl_vb),
    .red(red), .green(green), .blue(blue), .frame_cnt(frame_cnt),
    .underrun(underrun), .fmt_err(fmt_err), .running(running)
  );

  always #5 pxl_clk = ~pxl_clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, want);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    m_run   = 1'b0;
    m_n     = 0;
    e_hb    = 1'b1;
    e_vb    = 1'b1;
    e_hs    = 1'b0;
    e_vs    = 1'b0;
    e_und   = 1'b0;
    e_fmt   = 1'b0;
    fc_pend = 1'b0;
    e_rgb   = '0;
    e_fc    = '0;
  endfunction

  // Clock enable pattern: always on, one in three, or held off.
  initial begin
    int k;
    k = 0;
    forever begin
      @(negedge pxl_clk);
      case (cen_mode)
        0:       pxl_cen = 1'b1;
        1:       pxl_cen = (k % 3 == 0);
        default: pxl_cen = 1'b0;
      endcase
      k++;
    end
  end

  // Reference model: raster position is the count of enabled steps since priming.
  initial begin : monitor
    int   occ, h, v;
    bit   act, old_vb, acc;
    exp_t item;
    model_reset();
    forever begin
      @(posedge pxl_clk);
      if (rst_base) begin
        model_reset();
      end else begin
        occ = exp_q.size();
        acc = in_valid && (occ < DEPTH);
        if (fc_pend) begin
          e_fc++;
          fc_pend = 1'b0;
        end
        if (m_run && pxl_cen) begin
          h      = m_n % HTOTAL;
          v      = (m_n / HTOTAL) % VTOTAL;
          act    = (h < HACTIVE) && (v < VACTIVE);
          old_vb = e_vb;
          e_hb   = (h >= HACTIVE);
          e_vb   = (v >= VACTIVE);
          e_hs   = (h >= HS_START) && (h < HS_START + HS_LEN);
          e_vs   = (v >= VS_START) && (v < VS_START + VS_LEN);
          e_rgb  = '0;
          if (act) begin
            if (occ > 0) begin
              item  = exp_q.pop_front();
              e_rgb = item.rgb;
              if (item.bad) e_fmt = 1'b1;
            end else begin
              e_und = 1'b1;
            end
          end
          if (e_vb && !old_vb) fc_pend = 1'b1;
          m_n++;
        end
        if (acc) begin
          item.rgb = {in_data[23:20], in_data[15:12], in_data[7:4]};
          item.bad = (in_data[31:24] != 8'hff);
          exp_q.push_back(item);
        end
        if (!m_run && occ >= PRIME) m_run = 1'b1;
        #1;
        check("pxl_hb",    32'(pxl_hb),   32'(e_hb));
        check("pxl_vb",    32'(pxl_vb),   32'(e_vb));
        check("HS",        32'(HS),       32'(e_hs));
        check("VS",        32'(VS),       32'(e_vs));
        check("rgb",       32'({red, green, blue}), 32'(e_rgb));
        check("frame_cnt", frame_cnt,     e_fc);
        check("underrun",  32'(underrun), 32'(e_und));
        check("fmt_err",   32'(fmt_err),  32'(e_fmt));
        check("running",   32'(running),  32'(m_run));
        check("in_ready",  32'(in_ready), 32'(exp_q.size() < DEPTH));
      end
    end
  end

  // Offers words until n are accepted or the cycle budget runs out.
  task automatic push_words(input int n, input int bad_idx, input bit gaps,
                            input bit det, input int max_cycles);
    int sent, cyc;
    bit acc;
    sent = 0;
    cyc  = 0;
    while (sent < n && cyc < max_cycles) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (sent == bad_idx)  in_data = 32'h7FF0F0F0;
      else if (det)         in_data = 32'hFFA0B0C0 + 32'(sent);
      else                  in_data = {8'hff, 24'($urandom)};
      acc = in_valid && in_ready;
      @(negedge pxl_clk);
      cyc++;
      if (acc) sent++;
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) @(negedge pxl_clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hb"},       32'(pxl_hb),   32'd1);
    check({tag, "_vb"},       32'(pxl_vb),   32'd1);
    check({tag, "_rgb"},      32'({red, green, blue}), 32'd0);
    check({tag, "_frame"},    frame_cnt,     32'd0);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_running"},  32'(running),  32'd0);
    check({tag, "_sync"},     32'({HS, VS}), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge pxl_clk);
    rst_base = 1'b1;
    in_valid = 1'b0;
    idle(2);
    rst_base = 1'b0;
  endtask

  initial begin : stimulus
    int cyc;
    bit hit;
    idle(3);
    check_reset_outputs("por");
    rst_base = 1'b0;

    $display("test 1: small raster, cen=1");
    cen_mode = 0;
    push_words(12, -1, 1'b0, 1'b1, 100);
    push_words(70, -1, 1'b1, 1'b0, 400);
    idle(20);

    $display("test 2: underrun after 6 words");
    do_reset();
    push_words(6, -1, 1'b0, 1'b0, 50);
    idle(60);
    check("t2_underrun", 32'(underrun), 32'd1);

    $display("test 3: backpressure with cen held low");
    do_reset();
    cen_mode = 2;
    push_words(9, -1, 1'b0, 1'b1, 12);
    check("t3_in_ready", 32'(in_ready), 32'd0);
    cen_mode = 0;
    idle(30);

    $display("test 4: bad alpha on word 2");
    do_reset();
    push_words(10, 2, 1'b0, 1'b0, 60);
    idle(10);
    check("t4_fmt_err", 32'(fmt_err), 32'd1);

    $display("test 5: reset at v=1 h=2");
    do_reset();
    cyc = 0;
    hit = 1'b0;
    in_valid = 1'b1;
    while (!hit && cyc < 300) begin
      in_data = {8'hff, 24'($urandom)};
      @(negedge pxl_clk);
      cyc++;
      hit = m_run && (m_n == HTOTAL + 2);
    end
    check("t5_reached", 32'(hit), 32'd1);
    rst_base = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset_outputs("t5");
    idle(2);
    rst_base = 1'b0;
    idle(5);
    check("t5_idle_running", 32'(running), 32'd0);
    push_words(4, -1, 1'b0, 1'b1, 20);
    idle(2);
    check("t5_reprimed", 32'(running), 32'd1);

    $display("test 6: cen every third clock");
    do_reset();
    cen_mode = 1;
    push_words(12, -1, 1'b0, 1'b1, 100);
    push_words(60, -1, 1'b1, 1'b0, 900);
    idle(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
